jk_cmd_sequencer: RTL and testbench

//  Upstream driver for the JK flip-flop stage. Accepts op commands (hold/clear/set/toggle)

---
 rtl/jk_cmd_sequencer.sv | 126 ++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - command FIFO replaying hold/clear/set/toggle ops onto JK flip-flop drives
// Optional shadow flip-flop check enabled by defining JK_SHADOW_CHECK_EN.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [REP_W-1:0]         in_rep,
    input  logic                     flush,
    output logic                     j,
    output logic                     k,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
`ifdef JK_SHADOW_CHECK_EN
    ,
    input  logic                     q_fb,
    output logic                     err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [REP_W+1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [REP_W-1:0] cnt;
    state_t           state;
    logic             push;
    logic             pop;
    logic [REP_W+1:0] head;

    assign in_ready = (count != FULL_LVL);
    assign level    = count;
    assign busy     = (state == ISSUE);
    assign head     = mem[rptr];
    assign push     = in_valid && in_ready && !flush;
    // Pop whenever the driver is free: idle, or on the last cycle of the active command.
    assign pop      = !flush && (count != '0) && ((state == IDLE) || (cnt == '0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_rep, in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            cnt   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            cnt   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                j     <= head[1];
                k     <= head[0];
                cnt   <= head[REP_W+1:2];
                state <= ISSUE;
            end else if (state == ISSUE) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

`ifdef JK_SHADOW_CHECK_EN
    logic q_pred;

    // Shadow copy of the downstream flip-flop, advanced from the same j/k it sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pred <= 1'b0;
            err    <= 1'b0;
        end else if (flush) begin
            q_pred <= 1'b0;
            err    <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_pred <= 1'b0;
                2'b10:   q_pred <= 1'b1;
                2'b11:   q_pred <= ~q_pred;
                default: q_pred <= q_pred;
            endcase
            if (q_fb != q_pred) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - self-checking bench for jk_cmd_sequencer against a queue-based model
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [REP_W-1:0] in_rep;
    logic             flush;
    logic             j;
    logic             k;
    logic             busy;
    logic [2:0]       level;
`ifdef JK_SHADOW_CHECK_EN
    logic             q_fb;
    logic             err;
    logic             q_ff;
    logic             inj;
    bit               m_err;
`endif

    always #5 clk = ~clk;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rep   (in_rep),
        .flush    (flush),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .level    (level)
`ifdef JK_SHADOW_CHECK_EN
        ,
        .q_fb     (q_fb),
        .err      (err)
`endif
    );

`ifdef JK_SHADOW_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q_ff <= 1'b0;
        else if (flush) q_ff <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_ff <= 1'b0;
                2'b10:   q_ff <= 1'b1;
                2'b11:   q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end
    assign q_fb = q_ff ^ inj;
`endif

    typedef struct {
        logic [1:0] op;
        int         rep;
    } cmd_t;

    cmd_t       mq[$];
    int         m_rem;
    logic [1:0] m_out;
    bit         acc;
    bit         rec;
    logic [1:0] seen[$];
    int         checks;
    int         errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rem = 0;
        m_out = 2'b00;
`ifdef JK_SHADOW_CHECK_EN
        m_err = 1'b0;
`endif
    endtask

    // m_rem counts remaining cycles of the command currently shown on j/k.
    task automatic model_edge();
        bit   rdy;
        cmd_t c;
        acc = 1'b0;
`ifdef JK_SHADOW_CHECK_EN
        if (flush) m_err = 1'b0;
        else if (inj) m_err = 1'b1;
`endif
        if (flush) begin
            mq.delete();
            m_rem = 0;
            m_out = 2'b00;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (m_rem > 1) begin
                m_rem--;
            end else if (mq.size() > 0) begin
                c     = mq.pop_front();
                m_out = c.op;
                m_rem = c.rep + 1;
            end else begin
                m_out = 2'b00;
                m_rem = 0;
            end
            if (in_valid && rdy) begin
                c.op  = in_op;
                c.rep = int'(in_rep);
                mq.push_back(c);
                acc = 1'b1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk($sformatf("%s.j", tag), j, m_out[1]);
        chk($sformatf("%s.k", tag), k, m_out[0]);
        chk($sformatf("%s.busy", tag), busy, m_rem > 0);
        chk($sformatf("%s.level", tag), level, mq.size());
        chk($sformatf("%s.in_ready", tag), in_ready, mq.size() < DEPTH);
`ifdef JK_SHADOW_CHECK_EN
        chk($sformatf("%s.err", tag), err, m_err);
`endif
        if (rec && busy) seen.push_back({j, k});
    endtask

    task automatic send(input logic [1:0] op, input int rep);
        in_op    = op;
        in_rep   = rep[REP_W-1:0];
        in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            cycle("send");
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (mq.size() == 0 && m_rem == 0) break;
            cycle("drain");
        end
        chk("drain_done", (mq.size() == 0 && m_rem == 0), 1);
    endtask

    initial begin
        logic [1:0] ops[5];
        ops = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10};
        checks   = 0;
        errors   = 0;
        rec      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_rep   = '0;
        flush    = 1'b0;
`ifdef JK_SHADOW_CHECK_EN
        inj      = 1'b0;
`endif
        model_reset();
        #3;
        chk("rst.j", j, 0);
        chk("rst.k", k, 0);
        chk("rst.busy", busy, 0);
        chk("rst.level", level, 0);
        chk("rst.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cycle("idle");

        // Single set command with rep=2: three cycles of j=1,k=0.
        send(2'b10, 2);
        for (int i = 0; i < 3; i++) begin
            cycle("t2");
            chk("t2_j_hi", j, 1);
            chk("t2_k_lo", k, 0);
        end
        cycle("t2_end");
        chk("t2_j_off", j, 0);
        chk("t2_busy_off", busy, 0);

        // Back-to-back rep=0 commands replay without gaps.
        rec = 1'b1;
        seen.delete();
        for (int i = 0; i < 5; i++) send(ops[i], 0);
        drain();
        rec = 1'b0;
        chk("b2b_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk($sformatf("b2b_op%0d", i), seen[i], ops[i]);

        // Fill to DEPTH, then flush while a push is offered.
        for (int i = 0; i < 5; i++) send(2'(i), 5);
        chk("full_level", level, 4);
        chk("full_ready", in_ready, 0);
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_rep   = 4'd1;
        flush    = 1'b1;
        cycle("flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_j", j, 0);
        chk("flush_busy", busy, 0);
        for (int i = 0; i < 3; i++) cycle("post_flush");
        chk("post_flush_level", level, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_op    = 2'($urandom_range(0, 3));
            in_rep   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            flush    = ($urandom_range(0, 39) == 0);
            cycle("rnd");
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        drain();

        // Asynchronous reset in the middle of a long command.
        send(2'b11, 7);
        send(2'b10, 1);
        cycle("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.j", j, 0);
        chk("arst.k", k, 0);
        chk("arst.level", level, 0);
        chk("arst.busy", busy, 0);
        chk("arst.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst");

`ifdef JK_SHADOW_CHECK_EN
        send(2'b11, 3);
        drain();
        chk("shadow_clean", err, 0);
        inj = 1'b1;
        cycle("inject");
        inj = 1'b0;
        chk("shadow_set", err, 1);
        for (int i = 0; i < 3; i++) cycle("sticky");
        chk("shadow_sticky", err, 1);
        flush = 1'b1;
        cycle("shadow_flush");
        flush = 1'b0;
        chk("shadow_cleared", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
